// File: rtl/serial_word_rx.sv
// Serial frame receiver: start, 7 data bits LSB first, optional parity, stop.
// Delivers a registered 7-bit word with one-cycle valid/error strobes.
module serial_word_rx #(
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sin,
    input  logic       bit_en,
    output logic [6:0] data,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic [6:0] shift_q, shift_d;
    logic [6:0] data_q, data_d;
    logic       par_q, par_d;
    logic       valid_q, valid_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;
    logic       busy_q, busy_d;
    logic       par_ok;

    // Without a parity bit every frame counts as parity-good.
    assign par_ok = !PARITY_EN || (par_q == (^shift_q ^ PARITY_ODD));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        data_d  = data_q;
        par_d   = par_q;
        valid_d = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        if (bit_en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!sin) begin
                        state_d = S_DATA;
                        count_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d[count_q] = sin;
                    if (count_q == 3'd6) begin
                        count_d = 3'd0;
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        count_d = count_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    par_d   = sin;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    ferr_d  = !sin;
                    perr_d  = !par_ok;
                    if (sin && par_ok) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= 3'd0;
            shift_q <= 7'd0;
            data_q  <= 7'd0;
            par_q   <= 1'b0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            par_q   <= par_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Frame receiver that assembles a 7-bit word from a serial bit stream and delivers it, with a one-cycle valid strobe, to the 7-bit parallel register stage downstream. It sits directly upstream of that register: `data` drives the register's `d` input, and `data_valid` qualifies the load. Bit timing comes from an external one-cycle `bit_en` strobe; the block does no oversampling.

## Interface
- `PARITY_EN`, default 1: 1 means the frame carries a parity bit between data and stop; 0 means no parity bit.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `sin` input, 1 bit: serial line; idles high.
- `bit_en` input, 1 bit: sample strobe; `sin` is sampled only on edges where `bit_en`=1.
- `data` output, 7 bits: last good word received, LSB first on the line.
- `data_valid` output, 1 bit: one-cycle pulse when `data` has just been updated.
- `parity_err` output, 1 bit: one-cycle pulse on a parity mismatch.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit sampled as 0.
- `busy` output, 1 bit: 1 whenever the state is not IDLE.

## Operation
- Frame format: start (0), d0..d6 (LSB first), parity (only if `PARITY_EN`), stop (1).
- States and transitions, each evaluated only on edges with `bit_en`=1:
  - IDLE: `sin`=0 goes to DATA and clears the bit counter. `sin`=1 stays in IDLE.
  - DATA: shifts `sin` into the shift register at position `count` and increments `count` (3-bit, 0..6). After the sample at `count`=6, goes to PARITY if `PARITY_EN`, else to STOP.
  - PARITY: captures the parity bit, then goes to STOP.
  - STOP: evaluates the frame and always returns to IDLE.
- Parity check: the captured bit must equal XOR(d0..d6) XOR `PARITY_ODD`.
- STOP outcomes:
  - Stop bit 1 and parity OK: load `data` from the shift register and pulse `data_valid`.
  - Stop bit 0: pulse `frame_err`; `data` is unchanged.
  - Parity mismatch: pulse `parity_err`; `data` is unchanged.
  - Stop bit 0 and parity mismatch together: pulse both `frame_err` and `parity_err`; no `data_valid`.
- Edges with `bit_en`=0 hold all state. The shift register, counter and state do not change.
- No false-start rejection: a 0 sampled in IDLE always commits to a full frame.
- A new start bit is accepted on the first `bit_en` edge after returning to IDLE. No idle gap is required.

## Timing
- Reset values: state IDLE, count 0, shift register 0, `data`=7'b0000000, `data_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
- All outputs are registered.
- `data_valid`, `parity_err` and `frame_err` are high for exactly the one cycle following the edge that samples the stop bit. They are never high for two consecutive cycles, even if `bit_en` is held at 1.
- `data` changes only on a good-frame edge and holds its value indefinitely after that.
- Latency from the start-bit sample edge to `data_valid` high: 9 `bit_en` edges with parity, 8 without.
- `busy` rises the cycle after the start-bit edge and falls the cycle after the stop-bit edge, coincident with the result pulse.
- Reset asserted mid-frame: the frame is abandoned and no pulse is issued. Reset has priority over `bit_en`.

## Test plan
- Reset check: assert `reset` for 2 cycles with `sin`=1 -> all outputs at their reset values, `busy`=0.
- Good frame (`PARITY_EN`=1, even parity), one `bit_en` every 4 cycles: send sin 0, 0,1,0,1,0,1,0, 1, 1 -> `data`=7'b0101010, a single `data_valid` pulse, no error pulses.
- Bad parity: same frame with parity bit 0 -> `parity_err` pulses once, no `data_valid`, `data` stays 7'b0101010 from the previous frame.
- Bad stop bit: frame with data 7'b1111111, parity 1, stop 0 -> `frame_err` pulses once, `data` unchanged. A following good frame with data 7'b0000001 and parity 1 -> `data`=7'b0000001.
- Mid-frame reset: assert `reset` after 4 data bits, then send a full good frame with data 7'b1000000 -> no pulse for the aborted frame, then `data`=7'b1000000 with `data_valid`.
- `bit_en` held at 1 continuously with `PARITY_EN`=0: back-to-back frames 7'b0000011 and 7'b1100000, no idle between them -> two `data_valid` pulses exactly 9 cycles apart, each with the correct `data`.
